hazard_forward_ctrl: RTL and testbench
======================================

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 SHALL have clock/reset: clk in 1 (rising edge); rst in 1 (one clock; reset synchronous, active-high).
REQ-002 SHALL have ID-stage inputs:
  - id_valid 1: a real instruction is in ID.
  - id_rs 5, id_rt 5: source register fields.
  - id_uses_rs 1, id_uses_rt 1: instruction reads that source.
  - id_dest 5: destination already resolved by RegDst (rt, rd or 31).
  - id_reg_write 1, id_mem_read 1: control-unit values.
  - id_jr 1: instruction is jr.
  - id_branch_taken 1: branch decided in ID.
  - id_jump 1: j or jal.
REQ-003 SHALL have outputs:
  - fwd_a 2, fwd_b 2: EX operand selects; 0 = register file, 1 = EX/MEM forward, 2 = MEM/WB forward.
  - stall_sel 1: zeroes ID/EX RegWrite/MemWrite.
  - pc_write 1, ifid_write 1: PC and IF/ID enables.
  - ifid_flush 1: squash IF/ID.
  - stall_count 16: saturating stall-cycle counter.

Function
REQ-004 SHALL keep shadow pipeline registers ex_{dest,rs,rt,uses_rs,uses_rt,reg_write,mem_read}, mem_{dest,reg_write} and wb_{dest,reg_write}, advanced every clk.
REQ-005 SHALL, on a non-stall cycle, load ex_* from ID inputs gated by id_valid, and load ex_reg_write/ex_mem_read = 0 on a stall cycle (bubble); mem_* <= ex_*, wb_* <= mem_* always.
REQ-006 SHALL register fwd_a/fwd_b one cycle ahead: computed in ID from id_rs/id_rt against ex_* (becomes EX/MEM) and mem_* (becomes MEM/WB), valid during the instruction's EX cycle.
REQ-007 fwd_a SHALL be next-1 if ex_reg_write & ex_dest!=0 & ex_dest==id_rs & id_uses_rs; else 2 if mem_reg_write & mem_dest!=0 & mem_dest==id_rs & id_uses_rs; else 0; fwd_b identical with rt; the nearer stage wins on double match.
REQ-008 SHALL register fwd_a/fwd_b = 0 on a stall cycle (bubble enters EX).
REQ-009 SHALL combinationally assert load-use stall when id_valid & ex_mem_read & ex_dest!=0 & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest)).
REQ-010 SHALL combinationally assert jr stall when id_valid & id_jr & id_rs!=0 & ((ex_reg_write & ex_dest==id_rs) | (mem_reg_write & mem_dest==id_rs)); a jr after lw thus stalls 2 cycles, after ALU op 2 cycles, with 1 intervening instruction 1 cycle.
REQ-011 During stall: stall_sel=1, pc_write=0, ifid_write=0, ifid_flush=0; otherwise stall_sel=0, pc_write=1, ifid_write=1.
REQ-012 ifid_flush SHALL be 1 when not stalled and (id_branch_taken | id_jump | id_jr); stall suppresses flush, redirect and flush occur on the cycle stall clears.
REQ-013 Register 0 SHALL never cause forwarding or stall.
REQ-014 stall_count SHALL increment by 1 each stall cycle and hold at 16'hFFFF.

Reset
REQ-015 On rst at a clk edge: all shadow registers 0, fwd_a=fwd_b=0, stall_count=0; combinational outputs then yield stall_sel=0, pc_write=1, ifid_write=1, ifid_flush=0 unless ID inputs request otherwise.
REQ-016 rst during a stall SHALL cancel it next cycle (shadow pipeline empty) with no residual bubble.

Structure
REQ-017 Forward-select encodings (FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2) SHALL live in the shared CPU constants package with the mux control encodings.
REQ-018 One sub-module, hazard_src_compare (5-bit dest/source match with reg-0 and write-enable qualification), SHALL be instantiated per comparison.

Verification
REQ-019 add $3 then add $4,$3,$5 back-to-back -> fwd_a=1 in the consumer's EX cycle, no stall.
REQ-020 add $3; nop; sub $6,$7,$3 -> fwd_b=2 in sub's EX, fwd_a=0.
REQ-021 lw $2; add $8,$2,$2 -> one stall cycle (pc_write=0, stall_sel=1), then fwd_a=fwd_b=2, stall_count=1.
REQ-022 lw $31; jr $31 -> two stall cycles, then ifid_flush=1 for one cycle, stall_count=2.
REQ-023 add $0,$1,$2; add $4,$0,$0 -> fwd_a=fwd_b=0, no stall.
REQ-024 rst asserted in the first cycle of a load-use stall -> next cycle stall_sel=0, pc_write=1, fwd 0, stall_count=0.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared CPU constants: mux-control encodings and hazard-unit payload types.
package hazard_forward_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    REGDST_RT = 2'd0,
    REGDST_RD = 2'd1,
    REGDST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic {
    ALUSRC_REG = 1'b0,
    ALUSRC_IMM = 1'b1
  } alu_src_e;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'd0,
    PCSRC_BRANCH = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_JR     = 2'd3
  } pc_src_e;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs;
    reg_idx_t rt;
    logic     uses_rs;
    logic     uses_rt;
    reg_idx_t dest;
    logic     reg_write;
    logic     mem_read;
    logic     jr;
    logic     branch_taken;
    logic     jump;
  } id_req_t;

  typedef struct packed {
    reg_idx_t dest;
    reg_idx_t rs;
    reg_idx_t rt;
    logic     uses_rs;
    logic     uses_rt;
    logic     reg_write;
    logic     mem_read;
  } ex_stage_t;

  typedef struct packed {
    reg_idx_t dest;
    logic     reg_write;
  } wr_stage_t;

  typedef struct packed {
    ex_stage_t ex;
    wr_stage_t mem;
    wr_stage_t wb;
  } shadow_t;

  // Nearer producer wins when both later stages match.
  function automatic fwd_sel_e fwd_pick(logic near_hit, logic far_hit);
    if (near_hit) return FWD_EXMEM;
    if (far_hit)  return FWD_MEMWB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage request and hazard/forwarding response bundle between pipeline and hazard unit.
interface hazard_forward_ctrl_if;
  import hazard_forward_ctrl_pkg::*;

  id_req_t              id;
  fwd_sel_e             fwd_a;
  fwd_sel_e             fwd_b;
  logic                 stall_sel;
  logic                 pc_write;
  logic                 ifid_write;
  logic                 ifid_flush;
  logic [CNT_W-1:0]     stall_count;
  shadow_t              shadow;

  modport master (
    output id,
    input  fwd_a, fwd_b, stall_sel, pc_write, ifid_write, ifid_flush, stall_count, shadow
  );

  modport slave (
    input  id,
    output fwd_a, fwd_b, stall_sel, pc_write, ifid_write, ifid_flush, stall_count, shadow
  );
endinterface

// File: rtl/hazard_forward_ctrl_src_compare.sv
// Qualified destination/source match: producer writes, consumer reads, and register 0 never matches.
module hazard_src_compare
  import hazard_forward_ctrl_pkg::*;
(
  input  reg_idx_t dest_i,
  input  reg_idx_t src_i,
  input  logic     wen_i,
  input  logic     uses_i,
  output logic     match_o
);

  assign match_o = wen_i & uses_i & (dest_i != '0) & (dest_i == src_i);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline, tracking EX/MEM/WB
// destinations in shadow registers so the forward selects are registered a cycle early.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_ctrl_if.slave hz
);

  ex_stage_t        ex_q, ex_d;
  wr_stage_t        mem_q, wb_q;
  fwd_sel_e         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic a_ex, a_mem, b_ex, b_mem, lu_rs, lu_rt, jr_ex, jr_mem;
  logic stall;

  hazard_src_compare u_a_ex  (.dest_i(ex_q.dest),  .src_i(hz.id.rs), .wen_i(ex_q.reg_write),
                              .uses_i(hz.id.uses_rs), .match_o(a_ex));
  hazard_src_compare u_a_mem (.dest_i(mem_q.dest), .src_i(hz.id.rs), .wen_i(mem_q.reg_write),
                              .uses_i(hz.id.uses_rs), .match_o(a_mem));
  hazard_src_compare u_b_ex  (.dest_i(ex_q.dest),  .src_i(hz.id.rt), .wen_i(ex_q.reg_write),
                              .uses_i(hz.id.uses_rt), .match_o(b_ex));
  hazard_src_compare u_b_mem (.dest_i(mem_q.dest), .src_i(hz.id.rt), .wen_i(mem_q.reg_write),
                              .uses_i(hz.id.uses_rt), .match_o(b_mem));

  // Load-use: the load's data is not ready until it leaves MEM.
  hazard_src_compare u_lu_rs (.dest_i(ex_q.dest), .src_i(hz.id.rs), .wen_i(ex_q.mem_read),
                              .uses_i(hz.id.valid & hz.id.uses_rs), .match_o(lu_rs));
  hazard_src_compare u_lu_rt (.dest_i(ex_q.dest), .src_i(hz.id.rt), .wen_i(ex_q.mem_read),
                              .uses_i(hz.id.valid & hz.id.uses_rt), .match_o(lu_rt));

  // jr reads rs in ID, so it waits for any in-flight producer to reach WB.
  hazard_src_compare u_jr_ex  (.dest_i(ex_q.dest),  .src_i(hz.id.rs), .wen_i(ex_q.reg_write),
                               .uses_i(hz.id.valid & hz.id.jr), .match_o(jr_ex));
  hazard_src_compare u_jr_mem (.dest_i(mem_q.dest), .src_i(hz.id.rs), .wen_i(mem_q.reg_write),
                               .uses_i(hz.id.valid & hz.id.jr), .match_o(jr_mem));

  assign stall = lu_rs | lu_rt | jr_ex | jr_mem;

  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    cnt_d   = cnt_q;
    if (!stall) begin
      fwd_a_d = fwd_pick(a_ex, a_mem);
      fwd_b_d = fwd_pick(b_ex, b_mem);
      if (hz.id.valid) begin
        ex_d.dest      = hz.id.dest;
        ex_d.rs        = hz.id.rs;
        ex_d.rt        = hz.id.rt;
        ex_d.uses_rs   = hz.id.uses_rs;
        ex_d.uses_rt   = hz.id.uses_rt;
        ex_d.reg_write = hz.id.reg_write;
        ex_d.mem_read  = hz.id.mem_read;
      end
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= '{dest: ex_q.dest, reg_write: ex_q.reg_write};
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.fwd_a       = fwd_a_q;
  assign hz.fwd_b       = fwd_b_q;
  assign hz.stall_count = cnt_q;
  assign hz.stall_sel   = stall;
  assign hz.pc_write    = ~stall;
  assign hz.ifid_write  = ~stall;
  assign hz.ifid_flush  = ~stall & (hz.id.branch_taken | hz.id.jump | hz.id.jr);
  assign hz.shadow      = '{ex: ex_q, mem: mem_q, wb: wb_q};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: instruction-history model plus directed scenarios.
module tb_hazard_forward_ctrl;
  import hazard_forward_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  bit   checking = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl_if hz();
  hazard_forward_ctrl dut (.clk(clk), .rst(rst), .hz(hz));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: the last two instructions that entered EX ([0] now in EX, [1] now in MEM).
  int m_dest [2];
  bit m_wr   [2];
  bit m_mrd  [2];
  int m_fa, m_fb, m_cnt;

  function automatic bit produces(int k, int r);
    return m_wr[k] && m_dest[k] != 0 && m_dest[k] == r;
  endfunction

  function automatic int m_fwd(bit uses, int r);
    if (!uses) return 0;
    if (produces(0, r)) return 1;
    if (produces(1, r)) return 2;
    return 0;
  endfunction

  function automatic bit m_stall();
    id_req_t id = hz.id;
    bit lu, js;
    lu = id.valid && m_mrd[0] && m_dest[0] != 0 &&
         ((id.uses_rs && int'(id.rs) == m_dest[0]) || (id.uses_rt && int'(id.rt) == m_dest[0]));
    js = id.valid && id.jr && id.rs != 0 && (produces(0, int'(id.rs)) || produces(1, int'(id.rs)));
    return lu || js;
  endfunction

  always @(posedge clk) begin
    bit s;
    if (rst) begin
      m_dest = '{0, 0}; m_wr = '{0, 0}; m_mrd = '{0, 0};
      m_fa = 0; m_fb = 0; m_cnt = 0;
    end else begin
      s = m_stall();
      m_fa = s ? 0 : m_fwd(hz.id.uses_rs, int'(hz.id.rs));
      m_fb = s ? 0 : m_fwd(hz.id.uses_rt, int'(hz.id.rt));
      if (s && m_cnt < 65535) m_cnt++;
      m_dest[1] = m_dest[0]; m_wr[1] = m_wr[0]; m_mrd[1] = m_mrd[0];
      if (s || !hz.id.valid) begin
        m_dest[0] = 0; m_wr[0] = 0; m_mrd[0] = 0;
      end else begin
        m_dest[0] = int'(hz.id.dest); m_wr[0] = hz.id.reg_write; m_mrd[0] = hz.id.mem_read;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit s;
    if (checking && !rst) begin
      s = m_stall();
      chk("fwd_a", int'(hz.fwd_a), m_fa);
      chk("fwd_b", int'(hz.fwd_b), m_fb);
      chk("stall_sel", int'(hz.stall_sel), int'(s));
      chk("pc_write", int'(hz.pc_write), int'(!s));
      chk("ifid_write", int'(hz.ifid_write), int'(!s));
      chk("ifid_flush", int'(hz.ifid_flush),
          int'(!s && (hz.id.branch_taken || hz.id.jump || hz.id.jr)));
      chk("stall_count", int'(hz.stall_count), m_cnt);
    end
  end

  function automatic id_req_t mk(int rs, int rt, bit urs, bit urt, int dest, bit wr, bit mrd,
                                 bit jr = 0, bit br = 0, bit jmp = 0);
    id_req_t r = '0;
    r.valid = 1'b1;
    r.rs = 5'(rs); r.rt = 5'(rt); r.uses_rs = urs; r.uses_rt = urt;
    r.dest = 5'(dest); r.reg_write = wr; r.mem_read = mrd;
    r.jr = jr; r.branch_taken = br; r.jump = jmp;
    return r;
  endfunction

  function automatic id_req_t alu(int d, int s, int t); return mk(s, t, 1, 1, d, 1, 0); endfunction
  function automatic id_req_t lw(int d, int b);         return mk(b, d, 1, 0, d, 1, 1); endfunction
  function automatic id_req_t jr_i(int r);              return mk(r, 0, 1, 0, 0, 0, 0, 1); endfunction
  function automatic id_req_t nop();                    return mk(0, 0, 0, 0, 0, 0, 0); endfunction

  // Present one instruction in ID, holding it while the model says the pipeline stalls.
  task automatic issue(input id_req_t ins);
    int n = 0;
    @(posedge clk); #2 hz.id = ins; #1;
    while (m_stall()) begin
      if (n == 4) begin
        chk("stall_bound", n, 3);
        break;
      end
      @(posedge clk); #3;
      n++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1; hz.id = nop();
    @(posedge clk); #2 rst = 1'b0; #1;
  endtask

  initial begin
    id_req_t r;
    rst = 1'b1;
    hz.id = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0; checking = 1'b1; #1;
    chk("rst_fwd_a", int'(hz.fwd_a), 0);
    chk("rst_fwd_b", int'(hz.fwd_b), 0);
    chk("rst_count", int'(hz.stall_count), 0);
    chk("rst_pc_write", int'(hz.pc_write), 1);
    chk("rst_shadow", int'(hz.shadow), 0);

    // add $3 ; add $4,$3,$5
    issue(alu(3, 1, 2)); issue(alu(4, 3, 5)); issue(nop());
    chk("b2b_fwd_a", int'(hz.fwd_a), 1);
    chk("b2b_fwd_b", int'(hz.fwd_b), 0);
    chk("b2b_count", int'(hz.stall_count), 0);

    // add $3 ; nop ; sub $6,$7,$3
    do_reset();
    issue(alu(3, 1, 2)); issue(nop()); issue(alu(6, 7, 3)); issue(nop());
    chk("gap_fwd_b", int'(hz.fwd_b), 2);
    chk("gap_fwd_a", int'(hz.fwd_a), 0);

    // lw $2 ; add $8,$2,$2
    do_reset();
    issue(lw(2, 1));
    @(posedge clk); #2 hz.id = alu(8, 2, 2); #1;
    chk("lu_stall_sel", int'(hz.stall_sel), 1);
    chk("lu_pc_write", int'(hz.pc_write), 0);
    chk("lu_ifid_write", int'(hz.ifid_write), 0);
    @(posedge clk); #3;
    chk("lu_release", int'(hz.stall_sel), 0);
    issue(nop());
    chk("lu_fwd_a", int'(hz.fwd_a), 2);
    chk("lu_fwd_b", int'(hz.fwd_b), 2);
    chk("lu_count", int'(hz.stall_count), 1);

    // lw $31 ; jr $31
    do_reset();
    issue(lw(31, 1));
    @(posedge clk); #2 hz.id = jr_i(31); #1;
    chk("jr_stall1", int'(hz.stall_sel), 1);
    chk("jr_noflush1", int'(hz.ifid_flush), 0);
    @(posedge clk); #3;
    chk("jr_stall2", int'(hz.stall_sel), 1);
    chk("jr_noflush2", int'(hz.ifid_flush), 0);
    @(posedge clk); #3;
    chk("jr_go", int'(hz.stall_sel), 0);
    chk("jr_flush", int'(hz.ifid_flush), 1);
    issue(nop());
    chk("jr_flush_off", int'(hz.ifid_flush), 0);
    chk("jr_count", int'(hz.stall_count), 2);

    // add $0,$1,$2 ; add $4,$0,$0
    do_reset();
    issue(alu(0, 1, 2)); issue(alu(4, 0, 0));
    chk("r0_nostall", int'(hz.stall_sel), 0);
    issue(nop());
    chk("r0_fwd_a", int'(hz.fwd_a), 0);
    chk("r0_fwd_b", int'(hz.fwd_b), 0);

    // Reset in the first load-use stall cycle
    do_reset();
    issue(lw(2, 1));
    @(posedge clk); #2 hz.id = alu(8, 2, 2); #1;
    chk("rs_stall", int'(hz.stall_sel), 1);
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0; #1;
    chk("rs_stall_sel", int'(hz.stall_sel), 0);
    chk("rs_pc_write", int'(hz.pc_write), 1);
    chk("rs_fwd_a", int'(hz.fwd_a), 0);
    chk("rs_count", int'(hz.stall_count), 0);

    // Double match: nearer stage wins
    do_reset();
    issue(alu(5, 1, 2)); issue(alu(5, 3, 4)); issue(alu(6, 5, 5)); issue(nop());
    chk("near_fwd_a", int'(hz.fwd_a), 1);
    chk("near_fwd_b", int'(hz.fwd_b), 1);

    // jr after ALU op, then jr with one intervening instruction
    do_reset();
    issue(alu(9, 1, 2)); issue(jr_i(9));
    chk("jralu_flush", int'(hz.ifid_flush), 1);
    chk("jralu_count", int'(hz.stall_count), 2);
    do_reset();
    issue(alu(9, 1, 2)); issue(nop()); issue(jr_i(9));
    chk("jrgap_count", int'(hz.stall_count), 1);

    // Branch and jump redirects; invalid ID slot never stalls
    do_reset();
    issue(mk(1, 2, 1, 1, 0, 0, 0, 0, 1, 0));
    chk("br_flush", int'(hz.ifid_flush), 1);
    issue(mk(0, 0, 0, 0, 31, 1, 0, 0, 0, 1));
    chk("j_flush", int'(hz.ifid_flush), 1);
    issue(lw(2, 1));
    r = alu(8, 2, 2); r.valid = 1'b0;
    issue(r);
    chk("inv_nostall", int'(hz.stall_sel), 0);

    // Mixed instruction stream over a small register set, checked cycle by cycle
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int k = $urandom_range(0, 5);
      int a = $urandom_range(0, 3);
      int b = $urandom_range(0, 3);
      int d = $urandom_range(0, 3);
      case (k)
        0, 1: r = alu(d, a, b);
        2:    r = lw(d, a);
        3:    r = jr_i(a);
        4:    r = mk(a, b, 1, 1, 0, 0, 0, 0, 1, 0);
        default: r = nop();
      endcase
      r.valid = ($urandom_range(0, 7) != 0);
      issue(r);
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
